// File: rtl/wb_pkg.sv
// Shared Wishbone master definitions: bus widths, FSM state type and the
// registered request bundle presented on the wbm_* outputs.
package wb_pkg;

   localparam int WB_ADR_W = 31;
   localparam int WB_DAT_W = 32;
   localparam int WB_SEL_W = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      DONE = 2'd2
   } wb_state_e;

   typedef struct packed {
      logic [WB_ADR_W-1:0] adr;
      logic [WB_DAT_W-1:0] dat;
      logic [WB_SEL_W-1:0] sel;
      logic                we;
   } wb_req_t;

endpackage

// File: rtl/wb_timeout_ctr.sv
// Saturating stall counter: expired rises once TIMEOUT-1 enabled cycles have
// been counted since the last clear, and the count never wraps.
module wb_timeout_ctr #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt;

   assign expired = (cnt == LIMIT);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         cnt <= '0;
      else if (clear)
         cnt <= '0;
      else if (enable && !expired)
         cnt <= cnt + CW'(1);
   end

endmodule

// File: rtl/wb_master_bridge.sv
// Single-outstanding core-to-Wishbone bridge: latches a core request, runs one
// classic Wishbone cycle with timeout, and returns data with a ready pulse.
module wb_master_bridge
   import wb_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                req_i,
   input  logic                we_i,
   input  logic [31:1]         adr_i,
   input  logic [1:0]          sel_i,
   input  logic [31:0]         dat_i,
   output logic [31:0]         dat_o,
   output logic                ready_o,
   output logic                err_o,
   output logic                busy_o,
   output logic [31:1]         wbm_adr_o,
   output logic [31:0]         wbm_dat_o,
   output logic [1:0]          wbm_sel_o,
   output logic                wbm_we_o,
   output logic                wbm_cyc_o,
   output logic                wbm_stb_o,
   input  logic [31:0]         wbm_dat_i,
   input  logic                wbm_ack_i
);

   wb_state_e state_q, state_d;
   wb_req_t   req_q, req_d;
   logic      cyc_q, cyc_d;
   logic [WB_DAT_W-1:0] rdat_q, rdat_d;
   logic      ready_q, ready_d;
   logic      err_q, err_d;
   logic      busy_q, busy_d;
   logic      ctr_clr, ctr_en, ctr_expired;

   wb_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clear   (ctr_clr),
      .enable  (ctr_en),
      .expired (ctr_expired)
   );

   // Ack is only consulted in BUS, so a stray ack with stb low has no effect.
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      cyc_d   = 1'b0;
      rdat_d  = rdat_q;
      ready_d = 1'b0;
      err_d   = 1'b0;
      ctr_clr = 1'b0;
      ctr_en  = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_i) begin
               req_d   = '{adr: adr_i, dat: dat_i, sel: sel_i, we: we_i};
               cyc_d   = 1'b1;
               ctr_clr = 1'b1;
               state_d = BUS;
            end
         end
         BUS: begin
            cyc_d = 1'b1;
            if (wbm_ack_i) begin
               if (!req_q.we)
                  rdat_d = wbm_dat_i;
               ready_d = 1'b1;
               cyc_d   = 1'b0;
               state_d = DONE;
            end else if (ctr_expired) begin
               ready_d = 1'b1;
               err_d   = 1'b1;
               cyc_d   = 1'b0;
               state_d = DONE;
            end else begin
               ctr_en = 1'b1;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         req_q   <= '0;
         cyc_q   <= 1'b0;
         rdat_q  <= '0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         cyc_q   <= cyc_d;
         rdat_q  <= rdat_d;
         ready_q <= ready_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
      end
   end

   assign wbm_adr_o = req_q.adr;
   assign wbm_dat_o = req_q.dat;
   assign wbm_sel_o = req_q.sel;
   assign wbm_we_o  = req_q.we;
   assign wbm_cyc_o = cyc_q;
   assign wbm_stb_o = cyc_q;
   assign dat_o     = rdat_q;
   assign ready_o   = ready_q;
   assign err_o     = err_q;
   assign busy_o    = busy_q;

endmodule

// File: tb/tb_wb_master_bridge.sv
// Randomized bench for wb_master_bridge against a transaction-level model of
// stb window length, completion latency, error flag and returned data.
module tb_wb_master_bridge;

   localparam int TO = 8;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        req_i = 1'b0;
   logic        we_i = 1'b0;
   logic [31:1] adr_i = '0;
   logic [1:0]  sel_i = '0;
   logic [31:0] dat_i = '0;
   logic [31:0] dat_o;
   logic        ready_o, err_o, busy_o;
   logic [31:1] wbm_adr_o;
   logic [31:0] wbm_dat_o;
   logic [1:0]  wbm_sel_o;
   logic        wbm_we_o, wbm_cyc_o, wbm_stb_o;
   logic [31:0] wbm_dat_i = '0;
   logic        wbm_ack_i = 1'b0;

   int passed = 0;
   int total  = 0;
   logic [31:0] exp_dat = '0;

   wb_master_bridge #(.TIMEOUT(TO)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .adr_i(adr_i),
      .sel_i(sel_i), .dat_i(dat_i), .dat_o(dat_o), .ready_o(ready_o),
      .err_o(err_o), .busy_o(busy_o), .wbm_adr_o(wbm_adr_o),
      .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o), .wbm_we_o(wbm_we_o),
      .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_dat_i(wbm_dat_i),
      .wbm_ack_i(wbm_ack_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   // Drives one access; the slave acks on stb cycle ack_at (0 = never).
   task automatic run_access(input logic we, input logic [31:1] adr,
                             input logic [1:0] sel, input logic [31:0] dat,
                             input logic [31:0] rdata, input int ack_at,
                             output int stb_len, output int lat,
                             output int rdy_cnt, output int err_cnt,
                             output bit stable, output bit done_busy,
                             output bit idle_busy);
      stb_len = 0; lat = 0; rdy_cnt = 0; err_cnt = 0; stable = 1;
      done_busy = 0; idle_busy = 1;
      req_i = 1'b1; we_i = we; adr_i = adr; sel_i = sel; dat_i = dat;
      step();
      req_i = 1'b0; dat_i = $urandom; adr_i = 31'($urandom);
      for (int k = 1; k <= 40; k++) begin
         if (wbm_stb_o) begin
            stb_len++;
            if (!wbm_cyc_o || wbm_adr_o !== adr || wbm_dat_o !== dat ||
                wbm_sel_o !== sel || wbm_we_o !== we)
               stable = 0;
         end
         wbm_ack_i = wbm_stb_o && (k == ack_at);
         wbm_dat_i = wbm_ack_i ? rdata : $urandom;
         step();
         if (err_o) err_cnt++;
         if (ready_o) begin
            rdy_cnt++;
            lat = k + 1;
            done_busy = busy_o && !wbm_stb_o;
            break;
         end
      end
      wbm_ack_i = 1'b0;
      step();
      if (ready_o) rdy_cnt++;
      if (err_o) err_cnt++;
      idle_busy = busy_o;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      step(); step();
      total++;
      if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, ready_o, err_o, busy_o} !== 6'b0) begin
         $display("FAIL reset_ctrl got %b want 000000",
                  {wbm_cyc_o, wbm_stb_o, wbm_we_o, ready_o, err_o, busy_o});
      end else passed++;
      total++;
      if ({wbm_adr_o, wbm_dat_o, wbm_sel_o, dat_o} !== '0) begin
         $display("FAIL reset_data adr=%h dat=%h sel=%b dat_o=%h want 0",
                  wbm_adr_o, wbm_dat_o, wbm_sel_o, dat_o);
      end else passed++;
      rst_i = 1'b0;
      exp_dat = '0;
      step();
   endtask

   task automatic test_read_fast();
      int len, lat, rdy, err; bit st, db, ib;
      logic [31:1] a;
      a = 31'(32'h0000_1000 >> 1);
      run_access(1'b0, a, 2'b11, 32'h0, 32'hCAFE_F00D, 1, len, lat, rdy, err, st, db, ib);
      exp_dat = 32'hCAFE_F00D;
      total++; if (len !== 1) $display("FAIL read_stb_len got %0d want 1", len); else passed++;
      total++; if (lat !== 2) $display("FAIL read_latency got %0d want 2", lat); else passed++;
      total++; if (dat_o !== exp_dat) $display("FAIL read_data got %h want %h", dat_o, exp_dat); else passed++;
      total++; if (rdy !== 1 || err !== 0) $display("FAIL read_ready_err got %0d/%0d want 1/0", rdy, err); else passed++;
      total++; if (!st || !db || ib) $display("FAIL read_busy_stable got %0d%0d%0d want 110", st, db, ib); else passed++;
   endtask

   task automatic test_write_wait();
      int len, lat, rdy, err; bit st, db, ib;
      run_access(1'b1, 31'h0ABC_DEF0, 2'b11, 32'h1234_5678, 32'hDEAD_BEEF, 4,
                 len, lat, rdy, err, st, db, ib);
      total++; if (len !== 4) $display("FAIL write_stb_len got %0d want 4", len); else passed++;
      total++; if (!st) $display("FAIL write_stable got 0 want 1"); else passed++;
      total++; if (rdy !== 1 || err !== 0) $display("FAIL write_ready_err got %0d/%0d want 1/0", rdy, err); else passed++;
      total++; if (dat_o !== exp_dat) $display("FAIL write_dat_o got %h want %h", dat_o, exp_dat); else passed++;
   endtask

   task automatic test_timeout();
      int len, lat, rdy, err; bit st, db, ib;
      run_access(1'b0, 31'h11, 2'b01, 32'h0, 32'h5555_AAAA, 0, len, lat, rdy, err, st, db, ib);
      total++; if (len !== TO) $display("FAIL timeout_stb_len got %0d want %0d", len, TO); else passed++;
      total++; if (rdy !== 1 || err !== 1) $display("FAIL timeout_ready_err got %0d/%0d want 1/1", rdy, err); else passed++;
      total++; if (dat_o !== exp_dat) $display("FAIL timeout_dat_o got %h want %h", dat_o, exp_dat); else passed++;
      total++; if (!db || ib) $display("FAIL timeout_busy got %0d%0d want 10", db, ib); else passed++;
   endtask

   task automatic test_ack_at_limit();
      int len, lat, rdy, err; bit st, db, ib;
      run_access(1'b0, 31'h22, 2'b10, 32'h0, 32'h0BAD_F00D, TO, len, lat, rdy, err, st, db, ib);
      exp_dat = 32'h0BAD_F00D;
      total++; if (len !== TO) $display("FAIL limit_stb_len got %0d want %0d", len, TO); else passed++;
      total++; if (rdy !== 1 || err !== 0) $display("FAIL limit_ready_err got %0d/%0d want 1/0", rdy, err); else passed++;
      total++; if (dat_o !== exp_dat) $display("FAIL limit_data got %h want %h", dat_o, exp_dat); else passed++;
   endtask

   task automatic test_stray_ack();
      int rdy = 0, bsy = 0;
      for (int k = 0; k < 4; k++) begin
         wbm_ack_i = 1'b1; wbm_dat_i = $urandom;
         step();
         if (ready_o) rdy++;
         if (busy_o || wbm_stb_o) bsy++;
      end
      wbm_ack_i = 1'b0;
      total++;
      if (rdy !== 0 || bsy !== 0 || dat_o !== exp_dat)
         $display("FAIL stray_ack ready=%0d busy=%0d dat_o=%h want 0 0 %h", rdy, bsy, dat_o, exp_dat);
      else passed++;
   endtask

   task automatic test_reset_mid_bus();
      int len, lat, rdy, err; bit st, db, ib;
      logic [31:0] r;
      req_i = 1'b1; we_i = 1'b0; adr_i = 31'h33; sel_i = 2'b11;
      step();
      req_i = 1'b0;
      step();
      total++; if (!wbm_stb_o) $display("FAIL rst_pre_stb got 0 want 1"); else passed++;
      rst_i = 1'b1;
      #1;
      total++;
      if (wbm_stb_o || wbm_cyc_o || ready_o)
         $display("FAIL rst_async got stb=%b cyc=%b rdy=%b want 000", wbm_stb_o, wbm_cyc_o, ready_o);
      else passed++;
      step();
      total++; if (ready_o || busy_o) $display("FAIL rst_hold got rdy=%b busy=%b want 00", ready_o, busy_o); else passed++;
      rst_i = 1'b0;
      exp_dat = '0;
      step();
      r = $urandom;
      run_access(1'b0, 31'h44, 2'b01, 32'h0, r, 2, len, lat, rdy, err, st, db, ib);
      exp_dat = r;
      total++;
      if (len !== 2 || rdy !== 1 || err !== 0 || dat_o !== exp_dat)
         $display("FAIL rst_recover got len=%0d rdy=%0d err=%0d dat=%h want 2 1 0 %h", len, rdy, err, dat_o, exp_dat);
      else passed++;
   endtask

   task automatic test_back_to_back();
      bit stb_h[16], busy_h[16];
      int rdy = 0, s0 = -1, e0 = -1, s1 = -1, gap_busy = 0;
      logic [31:0] r;
      r = $urandom;
      req_i = 1'b1; we_i = 1'b0; adr_i = 31'h55; sel_i = 2'b11;
      for (int k = 0; k < 16; k++) begin
         step();
         stb_h[k] = wbm_stb_o; busy_h[k] = busy_o;
         if (ready_o) rdy++;
         if (rdy >= 2) req_i = 1'b0;
         wbm_ack_i = wbm_stb_o; wbm_dat_i = r;
      end
      wbm_ack_i = 1'b0; req_i = 1'b0;
      exp_dat = r;
      for (int k = 0; k < 16; k++) begin
         if (stb_h[k] && s0 < 0) s0 = k;
         else if (!stb_h[k] && s0 >= 0 && e0 < 0) e0 = k;
         else if (stb_h[k] && e0 >= 0 && s1 < 0) s1 = k;
      end
      for (int k = 0; k < 16; k++)
         if (e0 >= 0 && k >= e0 && k < s1 && busy_h[k]) gap_busy++;
      total++; if (rdy !== 2) $display("FAIL b2b_ready got %0d want 2", rdy); else passed++;
      total++; if (s1 - e0 !== 2) $display("FAIL b2b_gap got %0d want 2", s1 - e0); else passed++;
      total++; if (gap_busy !== 1) $display("FAIL b2b_done_cycles got %0d want 1", gap_busy); else passed++;
      total++; if (dat_o !== exp_dat) $display("FAIL b2b_data got %h want %h", dat_o, exp_dat); else passed++;
      step(); step();
   endtask

   task automatic test_random();
      int len, lat, rdy, err; bit st, db, ib;
      int ack_at, exp_len, exp_err;
      logic we; logic [31:1] a; logic [1:0] s; logic [31:0] d, r;
      for (int n = 0; n < 12; n++) begin
         we = 1'($urandom); a = 31'($urandom); s = 2'($urandom);
         d = $urandom; r = $urandom;
         ack_at = $urandom_range(0, TO + 2);
         exp_err = (ack_at == 0 || ack_at > TO) ? 1 : 0;
         exp_len = exp_err ? TO : ack_at;
         if (!we && !exp_err) exp_dat = r;
         run_access(we, a, s, d, r, ack_at, len, lat, rdy, err, st, db, ib);
         total++;
         if (len !== exp_len || lat !== exp_len + 1 || rdy !== 1 || err !== exp_err ||
             !st || !db || ib || dat_o !== exp_dat)
            $display("FAIL rand_%0d got len=%0d lat=%0d rdy=%0d err=%0d st=%0d db=%0d ib=%0d dat=%h want len=%0d lat=%0d 1 err=%0d 1 1 0 dat=%h",
                     n, len, lat, rdy, err, st, db, ib, dat_o, exp_len, exp_len + 1, exp_err, exp_dat);
         else passed++;
      end
   endtask

   initial begin
      test_reset();
      test_read_fast();
      test_write_wait();
      test_timeout();
      test_ack_at_limit();
      test_stray_ack();
      test_reset_mid_bus();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
